// File: rtl/cmd_assembler_if.sv
// Byte-stream input and assembled-command output bundle of cmd_assembler.
// The master drives received bytes; the slave (the assembler) drives command outputs.
interface cmd_assembler_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_busy;
    logic        timeout_err;

    modport master (
        output rx_valid, rx_data,
        input  opcode, config_data, execute, cmd_busy, timeout_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output opcode, config_data, execute, cmd_busy, timeout_err
    );
endinterface

// File: rtl/cmd_assembler.sv
// Assembles SUMP short (1 byte) and long (opcode + 4 LSB-first argument bytes) commands
// from a byte stream, with an inter-byte timeout that discards stalled long commands.
module cmd_assembler #(
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned TW      = 17
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    cmd_assembler_if.slave  bus
);

    localparam bit            TIMER_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TIMER_LAST = TIMER_EN ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        ARGS = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    arg_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    shadow_op;
    logic [23:0]   shadow_arg;

    // Outputs move only on the edge that raises execute, so partial assembly never shows.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            arg_cnt         <= 2'd0;
            timer           <= '0;
            shadow_op       <= 8'h00;
            shadow_arg      <= 24'h0;
            bus.opcode      <= 8'h00;
            bus.config_data <= 32'h0;
            bus.execute     <= 1'b0;
            bus.cmd_busy    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.execute     <= 1'b0;
            bus.timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (!bus.rx_data[7]) begin
                            bus.opcode      <= bus.rx_data;
                            bus.config_data <= 32'h0;
                            bus.execute     <= 1'b1;
                        end else begin
                            shadow_op    <= bus.rx_data;
                            shadow_arg   <= 24'h0;
                            arg_cnt      <= 2'd0;
                            timer        <= '0;
                            state        <= ARGS;
                            bus.cmd_busy <= 1'b1;
                        end
                    end
                end
                ARGS: begin
                    if (bus.rx_valid) begin
                        timer <= '0;
                        if (arg_cnt == 2'd3) begin
                            bus.opcode      <= shadow_op;
                            bus.config_data <= {bus.rx_data, shadow_arg};
                            bus.execute     <= 1'b1;
                            bus.cmd_busy    <= 1'b0;
                            state           <= IDLE;
                            arg_cnt         <= 2'd0;
                        end else begin
                            unique case (arg_cnt)
                                2'd0:    shadow_arg[7:0]   <= bus.rx_data;
                                2'd1:    shadow_arg[15:8]  <= bus.rx_data;
                                default: shadow_arg[23:16] <= bus.rx_data;
                            endcase
                            arg_cnt <= arg_cnt + 2'd1;
                        end
                    end else if (TIMER_EN) begin
                        // A byte in the expiry cycle wins; only a silent cycle can time out.
                        if (timer == TIMER_LAST) begin
                            state           <= IDLE;
                            arg_cnt         <= 2'd0;
                            timer           <= '0;
                            bus.cmd_busy    <= 1'b0;
                            bus.timeout_err <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_assembler.sv
// Scoreboard bench for cmd_assembler: a byte-queue reference model predicts every cycle's
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_cmd_assembler;

    localparam int unsigned TMO  = 16;
    localparam int unsigned TWID = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_assembler_if bus ();

    cmd_assembler #(.TIMEOUT(TMO), .TW(TWID)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          cyc;
        bit          exec;
        bit [7:0]    op;
        bit [31:0]   cfg;
        bit          busy;
        bit          tmo;
    } exp_t;

    exp_t     q[$];
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_fail = 0;

    // Reference model: bytes of a partially received long command, plus silent-cycle count.
    bit [7:0]  pend[$];
    int        idle_run = 0;
    bit [7:0]  m_op = 8'h00;
    bit [31:0] m_cfg = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        idle_run = 0;
        m_op = 8'h00;
        m_cfg = 32'h0;
    endtask

    // Drive one cycle of stimulus (called at posedge+1) and queue the predicted response.
    task automatic step(input bit v, input bit [7:0] d);
        exp_t e;
        bus.rx_valid = v;
        bus.rx_data  = d;
        e.exec = 1'b0;
        e.tmo  = 1'b0;
        if (v) begin
            idle_run = 0;
            if (pend.size() == 0 && d < 8'h80) begin
                m_op = d;
                m_cfg = 32'h0;
                e.exec = 1'b1;
            end else begin
                pend.push_back(d);
                if (pend.size() == 5) begin
                    m_op = pend[0];
                    m_cfg = {pend[4], pend[3], pend[2], pend[1]};
                    e.exec = 1'b1;
                    pend.delete();
                end
            end
        end else if (pend.size() > 0) begin
            idle_run++;
            if (idle_run == int'(TMO)) begin
                e.tmo = 1'b1;
                pend.delete();
                idle_run = 0;
            end
        end
        e.op   = m_op;
        e.cfg  = m_cfg;
        e.busy = (pend.size() > 0);
        e.cyc  = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send(input bit [7:0] d);
        step(1'b1, d);
    endtask

    // Monitor: compare the DUT against whichever prediction is due this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("stale_prediction", 32'(e.cyc), 32'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("execute",     32'(bus.execute),     32'(e.exec));
                chk("cmd_busy",    32'(bus.cmd_busy),    32'(e.busy));
                chk("timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
                chk("opcode",      32'(bus.opcode),      32'(e.op));
                chk("config_data", bus.config_data,      e.cfg);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_opcode"},      32'(bus.opcode),      32'h0);
        chk({tag, "_config_data"}, bus.config_data,      32'h0);
        chk({tag, "_execute"},     32'(bus.execute),     32'h0);
        chk({tag, "_cmd_busy"},    32'(bus.cmd_busy),    32'h0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'h0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        chk_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short command
        send(8'h01); idle(3);
        // Long command with gaps
        send(8'hC0); idle(1); send(8'h78); idle(2); send(8'h56); idle(1);
        send(8'h34); idle(1); send(8'h12); idle(2);
        // Back-to-back short then long
        send(8'h02); send(8'h81); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); idle(2);
        // Timeout then recovery
        send(8'h80); send(8'h11); idle(20); send(8'h00); idle(2);
        // Byte on the 16th cycle keeps the command alive
        send(8'h80); send(8'h11); idle(15); send(8'h22); send(8'h33); send(8'h44); idle(2);
        // Consecutive shorts
        send(8'h03); send(8'h04); send(8'h05); idle(1);
        // Resync with five zeros
        send(8'hC0); send(8'h01);
        for (int i = 0; i < 5; i++) send(8'h00);
        idle(2);

        // Reset mid-command
        send(8'h82); send(8'h55);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midcmd_rst");
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h66); send(8'h77); send(8'h05); idle(2);

        // Randomized traffic with occasional stalls around the timeout boundary
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                idle(int'($urandom_range(TMO - 2, TMO + 2)));
            end else if ($urandom_range(0, 99) < 60) begin
                if ($urandom_range(0, 3) == 0) send(8'h80 | 8'($urandom));
                else send(8'h7F & 8'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(int'(TMO) + 4);

        @(negedge clk);
        #1;
        chk("predictions_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
